gpc_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the GPC RV32 core. It drives instruction fetch, holds the instruction register stable while the decode unit classifies it, issues data-memory accesses for loads and stores, and generates the PC and register-file write strobes. It sits between the instruction/data memory handshakes and the decode/execute datapath, and also counts retired instructions and traps on illegal opcodes, environment calls and bus timeouts.

---
 rtl/gpc_seq_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_gpc_seq_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpc_seq_ctrl.sv
// gpc_seq_ctrl
// Multi-cycle sequencer for the GPC RV32 core. Walks each instruction through
// fetch, decode, optional data-memory access and write-back, produces the
// IR/PC/register-file strobes, counts retired instructions and traps on
// ECALL/EBREAK, unsupported opcodes and memory handshake timeouts.
//
// Ports:
//   clk, rstn            clock and synchronous active-low reset
//   imem_req             instruction fetch request (FETCH)
//   imem_gnt/rvalid      fetch accept / fetch data valid
//   ir_we                instruction register load (FWAIT with imem_rvalid)
//   opcode               inst[6:0] from the instruction register
//   dmem_req, dmem_we    data access request, 1 = store (MEM)
//   dmem_gnt/rvalid      data accept / load data valid
//   pc_we, rf_we         PC and register-file write strobes (WB)
//   halt, illegal        sticky trap flags
//   bus_err              sticky memory-timeout flag
//   instret              retired instruction count
//   state                current FSM state for debug
module gpc_seq_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rstn,
    output logic             imem_req,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    output logic             ir_we,
    input  logic [6:0]       opcode,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_gnt,
    input  logic             dmem_rvalid,
    output logic             pc_we,
    output logic             rf_we,
    output logic             halt,
    output logic             illegal,
    output logic             bus_err,
    output logic [WIDTH-1:0] instret,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_FWAIT  = 4'd2,
        S_DECODE = 4'd3,
        S_EXEC   = 4'd4,
        S_MEM    = 4'd5,
        S_MWAIT  = 4'd6,
        S_WB     = 4'd7,
        S_HALT   = 4'd8,
        S_ERR    = 4'd9
    } state_t;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // The wait counter only has to reach TIMEOUT-1, so size it for that.
    localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int              LAST_I   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_I);
    localparam bit              TMO_EN   = (TIMEOUT != 0);

    state_t           cur;
    logic [CNT_W-1:0] tmo_cnt;
    logic             expired;
    logic             is_legal;
    logic             is_store;
    logic             is_load;
    logic             no_rf_write;

    // Expiry only matters when the awaited event is absent; the FSM checks
    // the event first so an event in the expiry cycle still wins.
    assign expired     = TMO_EN && (tmo_cnt == CNT_LAST);
    assign is_store    = (opcode == OP_STORE);
    assign is_load     = (opcode == OP_LOAD);
    assign no_rf_write = (opcode == OP_STORE) || (opcode == OP_BRANCH);

    // Opcodes the datapath can execute; SYSTEM is handled separately.
    always_comb begin
        is_legal = 1'b0;
        case (opcode)
            OP_OP, OP_IMM, OP_LOAD, OP_JALR, OP_STORE,
            OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL: is_legal = 1'b1;
            default:                             is_legal = 1'b0;
        endcase
    end

    // Strobes decode the state register; ir_we additionally follows
    // imem_rvalid so the IR captures data in the cycle it is valid.
    assign state    = cur;
    assign imem_req = (cur == S_FETCH);
    assign ir_we    = (cur == S_FWAIT) && imem_rvalid;
    assign dmem_req = (cur == S_MEM);
    assign dmem_we  = (cur == S_MEM) && is_store;
    assign pc_we    = (cur == S_WB);
    assign rf_we    = (cur == S_WB) && !no_rf_write;

    // Sequencer, wait-state counter, sticky flags and retire counter.
    // Every transition into a wait state clears the counter; staying in a
    // wait state without the event advances it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cur     <= S_IDLE;
            tmo_cnt <= '0;
            instret <= '0;
            halt    <= 1'b0;
            illegal <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            case (cur)
                S_IDLE: begin
                    cur     <= S_FETCH;
                    tmo_cnt <= '0;
                end
                S_FETCH: begin
                    if (imem_gnt) begin
                        cur     <= S_FWAIT;
                        tmo_cnt <= '0;
                    end else if (expired) begin
                        cur     <= S_ERR;
                        bus_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                S_FWAIT: begin
                    if (imem_rvalid) begin
                        cur <= S_DECODE;
                    end else if (expired) begin
                        cur     <= S_ERR;
                        bus_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                S_DECODE: begin
                    if (opcode == OP_SYSTEM) begin
                        cur  <= S_HALT;
                        halt <= 1'b1;
                    end else if (!is_legal) begin
                        cur     <= S_ERR;
                        illegal <= 1'b1;
                    end else if (is_load || is_store) begin
                        cur     <= S_MEM;
                        tmo_cnt <= '0;
                    end else begin
                        cur <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    cur <= S_WB;
                end
                S_MEM: begin
                    if (dmem_gnt) begin
                        cur     <= is_store ? S_WB : S_MWAIT;
                        tmo_cnt <= '0;
                    end else if (expired) begin
                        cur     <= S_ERR;
                        bus_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                S_MWAIT: begin
                    if (dmem_rvalid) begin
                        cur <= S_WB;
                    end else if (expired) begin
                        cur     <= S_ERR;
                        bus_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                S_WB: begin
                    cur     <= S_FETCH;
                    tmo_cnt <= '0;
                    instret <= instret + WIDTH'(1);
                end
                S_HALT:  cur <= S_HALT;
                S_ERR:   cur <= S_ERR;
                default: cur <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpc_seq_ctrl.sv
// tb_gpc_seq_ctrl
// Randomized bench for gpc_seq_ctrl. A cycle-by-cycle plan of expected
// states and memory responses is built up front from the instruction-level
// rules (phase lengths from handshake delays, traps, timeouts, resets), then
// replayed against the DUT while every output is compared each cycle.
module tb_gpc_seq_ctrl;

    localparam int TMO = 4;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_FETCH  = 4'd1;
    localparam logic [3:0] ST_FWAIT  = 4'd2;
    localparam logic [3:0] ST_DECODE = 4'd3;
    localparam logic [3:0] ST_EXEC   = 4'd4;
    localparam logic [3:0] ST_MEM    = 4'd5;
    localparam logic [3:0] ST_MWAIT  = 4'd6;
    localparam logic [3:0] ST_WB     = 4'd7;
    localparam logic [3:0] ST_HALT   = 4'd8;
    localparam logic [3:0] ST_ERR    = 4'd9;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYS    = 7'b1110011;
    localparam logic [6:0] LEGAL_OPS [9] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                             7'b1100111, 7'b0100011, 7'b1100011,
                                             7'b0110111, 7'b0010111, 7'b1101111};

    localparam int K_EXEC  = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;
    localparam int K_SYS   = 3;
    localparam int K_ILL   = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        imem_req, imem_gnt, imem_rvalid, ir_we;
    logic [6:0]  opcode;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic        pc_we, rf_we, halt, illegal, bus_err;
    logic [31:0] instret;
    logic [3:0]  state;

    gpc_seq_ctrl #(.WIDTH(32), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .imem_req   (imem_req),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .ir_we      (ir_we),
        .opcode     (opcode),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_gnt   (dmem_gnt),
        .dmem_rvalid(dmem_rvalid),
        .pc_we      (pc_we),
        .rf_we      (rf_we),
        .halt       (halt),
        .illegal    (illegal),
        .bus_err    (bus_err),
        .instret    (instret),
        .state      (state)
    );

    always #5 clk = ~clk;

    // One clock cycle of the plan: expected state, inputs to drive, and
    // how the architectural counters/flags change after this cycle.
    typedef struct {
        logic [3:0] st;
        bit         rst;
        bit         ig, irv, dg, drv;
        logic [6:0] op;
        bit         retire, sHalt, sIll, sBus;
    } step_t;

    step_t       plan[$];
    int          total = 0;
    int          bad = 0;
    int unsigned mInstret;
    bit          mHalt, mIll, mBus;

    function automatic bit nz();
        return ($urandom_range(0, 2) == 0);
    endfunction

    // Inputs not awaited in a given state get random noise, which the
    // sequencer must ignore.
    function automatic step_t mkStep(input logic [3:0] st, input logic [6:0] op);
        step_t s;
        s.st = st;  s.op = op;  s.rst = 1'b0;
        s.ig = nz(); s.irv = nz(); s.dg = nz(); s.drv = nz();
        s.retire = 1'b0; s.sHalt = 1'b0; s.sIll = 1'b0; s.sBus = 1'b0;
        return s;
    endfunction

    function automatic int classify(input logic [6:0] op);
        if (op == OP_SYS)   return K_SYS;
        if (op == OP_LOAD)  return K_LOAD;
        if (op == OP_STORE) return K_STORE;
        for (int i = 0; i < 9; i++)
            if (LEGAL_OPS[i] == op) return K_EXEC;
        return K_ILL;
    endfunction

    function automatic int pickDelay(input int fixed);
        if (fixed >= 0) return fixed;
        if ($urandom_range(0, 9) < 9) return int'($urandom_range(0, 2));
        return int'($urandom_range(3, 5));
    endfunction

    function automatic logic [6:0] randOp();
        int r;
        r = int'($urandom_range(0, 19));
        if (r == 0) return OP_SYS;
        if (r == 1) return 7'($urandom);
        return LEGAL_OPS[$urandom_range(0, 8)];
    endfunction

    // A wait state lasts until its event (delay cycles later) or until
    // TMO cycles pass without it, in which case bus_err follows.
    task automatic waitPhase(input logic [3:0] st, input int which, input int delay,
                             input logic [6:0] op, output bit timedOut);
        step_t s;
        int    n;
        timedOut = (delay >= TMO);
        n = timedOut ? TMO : delay + 1;
        for (int i = 0; i < n; i++) begin
            s = mkStep(st, op);
            case (which)
                0:       s.ig  = (i == delay);
                1:       s.irv = (i == delay);
                2:       s.dg  = (i == delay);
                default: s.drv = (i == delay);
            endcase
            s.sBus = timedOut && (i == n - 1);
            plan.push_back(s);
        end
    endtask

    // Sit in an absorbing state, then reset back to IDLE.
    task automatic tailReset(input logic [3:0] st, input int len);
        step_t s;
        for (int i = 0; i < len; i++) plan.push_back(mkStep(st, 7'($urandom)));
        s = mkStep(st, 7'($urandom));
        s.rst = 1'b1;
        plan.push_back(s);
        plan.push_back(mkStep(ST_IDLE, 7'($urandom)));
    endtask

    task automatic planInstr(input logic [6:0] op, input int gd, input int rd,
                             input int md, input int ld, input bit midReset,
                             input int tailLen);
        step_t      s;
        bit         to;
        int         kind;
        logic [6:0] junk;
        kind = classify(op);
        junk = 7'($urandom);
        waitPhase(ST_FETCH, 0, pickDelay(gd), junk, to);
        if (to) begin tailReset(ST_ERR, tailLen); return; end
        waitPhase(ST_FWAIT, 1, pickDelay(rd), junk, to);
        if (to) begin tailReset(ST_ERR, tailLen); return; end
        s = mkStep(ST_DECODE, op);
        s.sHalt = (kind == K_SYS);
        s.sIll  = (kind == K_ILL);
        plan.push_back(s);
        if (kind == K_SYS) begin tailReset(ST_HALT, tailLen); return; end
        if (kind == K_ILL) begin tailReset(ST_ERR, tailLen); return; end
        if (kind == K_LOAD || kind == K_STORE) begin
            waitPhase(ST_MEM, 2, pickDelay(md), op, to);
            if (to) begin tailReset(ST_ERR, tailLen); return; end
            if (kind == K_LOAD) begin
                if (midReset) begin
                    s = mkStep(ST_MWAIT, op);
                    s.drv = 1'b0;
                    s.rst = 1'b1;
                    plan.push_back(s);
                    s = mkStep(ST_IDLE, junk);
                    s.drv = 1'b1;
                    s.irv = 1'b1;
                    plan.push_back(s);
                    return;
                end
                waitPhase(ST_MWAIT, 3, pickDelay(ld), op, to);
                if (to) begin tailReset(ST_ERR, tailLen); return; end
            end
        end else begin
            plan.push_back(mkStep(ST_EXEC, op));
        end
        s = mkStep(ST_WB, op);
        s.retire = 1'b1;
        plan.push_back(s);
    endtask

    task automatic applyStimulus(input step_t s);
        rstn        = !s.rst;
        imem_gnt    = s.ig;
        imem_rvalid = s.irv;
        dmem_gnt    = s.dg;
        dmem_rvalid = s.drv;
        opcode      = s.op;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        step_t       s;
        logic [5:0]  expStrobe;
        logic [2:0]  expFlags;

        rstn = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; opcode = 7'd0;
        mInstret = 0; mHalt = 1'b0; mIll = 1'b0; mBus = 1'b0;

        plan.push_back(mkStep(ST_IDLE, 7'd0));
        planInstr(OP_IMM,   0, 0, 0, 0, 1'b0, 3);
        planInstr(OP_STORE, 0, 0, 3, 0, 1'b0, 3);
        planInstr(OP_LOAD,  0, 0, 0, 2, 1'b0, 3);
        planInstr(OP_IMM,   1, 2, 0, 0, 1'b0, 3);
        planInstr(7'h7F,    0, 0, 0, 0, 1'b0, 3);
        planInstr(OP_SYS,   0, 0, 0, 0, 1'b0, 100);
        planInstr(OP_IMM,   4, 0, 0, 0, 1'b0, 3);
        planInstr(OP_IMM,   3, 0, 0, 0, 1'b0, 3);
        planInstr(OP_LOAD,  0, 3, 3, 3, 1'b0, 3);
        planInstr(OP_LOAD,  0, 0, 4, 0, 1'b0, 3);
        planInstr(OP_LOAD,  0, 0, 0, 0, 1'b1, 3);
        planInstr(OP_BRANCH, 0, 0, 0, 0, 1'b0, 3);
        for (int n = 0; n < 250; n++)
            planInstr(randOp(), -1, -1, -1, -1, ($urandom_range(0, 9) == 0),
                      int'($urandom_range(1, 5)));

        repeat (3) @(posedge clk);

        for (int i = 0; i < plan.size(); i++) begin
            s = plan[i];
            @(negedge clk);
            applyStimulus(s);
            #1;
            expStrobe = {s.st == ST_FETCH,
                         (s.st == ST_FWAIT) && s.irv,
                         s.st == ST_MEM,
                         (s.st == ST_MEM) && (s.op == OP_STORE),
                         s.st == ST_WB,
                         (s.st == ST_WB) && (s.op != OP_STORE) && (s.op != OP_BRANCH)};
            expFlags  = {mHalt, mIll, mBus};
            checkOutput($sformatf("state@%0d", i), 32'(state), 32'(s.st));
            checkOutput($sformatf("strobes@%0d", i),
                        32'({imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we}), 32'(expStrobe));
            checkOutput($sformatf("flags@%0d", i), 32'({halt, illegal, bus_err}), 32'(expFlags));
            checkOutput($sformatf("instret@%0d", i), instret, mInstret);
            if (s.rst) begin
                mInstret = 0; mHalt = 1'b0; mIll = 1'b0; mBus = 1'b0;
            end else begin
                if (s.retire) mInstret++;
                if (s.sHalt)  mHalt = 1'b1;
                if (s.sIll)   mIll  = 1'b1;
                if (s.sBus)   mBus  = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
